// File: rtl/counter_display.sv
// Snapshots one selected 32-bit performance count and scans it out as eight
// hex digits on a time-multiplexed, active-low 7-segment display.
module counter_display #(
   parameter int unsigned DIV_W = 17,
   parameter bit          BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [31:0] Count_cycle,
   input  logic [31:0] CountB,
   input  logic [31:0] CountJ,
   input  logic [1:0]  sel,
   input  logic        hold,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned DIGIT_N = 8;
   localparam int unsigned SEG_W   = 8;
   localparam int unsigned SH_W    = IDX_W + 2;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGIT_N - 1);
   localparam logic [SEG_W-2:0] SEG_BLANK = '1;

   logic [DIV_W-1:0]   div_q, div_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   snap_q, snap_d;
   logic [DIGIT_N-1:0] an_q, an_d;
   logic [SEG_W-1:0]   seg_q, seg_d;

   logic [IDX_W-1:0]   nxt_idx_c;
   logic [SH_W-1:0]    shamt_c;
   logic [CNT_W-1:0]   upper_c;
   logic [CNT_W-1:0]   src_c;
   logic [NIB_W-1:0]   nib_c;
   logic               tick_c;
   logic               frame_end_c;
   logic               blank_c;
   logic               dp_n_c;

   // Active-low gfedcba pattern for one hex nibble
   function automatic logic [SEG_W-2:0] hex7(input logic [NIB_W-1:0] v);
      case (v)
         4'h0:    hex7 = 7'h40;
         4'h1:    hex7 = 7'h79;
         4'h2:    hex7 = 7'h24;
         4'h3:    hex7 = 7'h30;
         4'h4:    hex7 = 7'h19;
         4'h5:    hex7 = 7'h12;
         4'h6:    hex7 = 7'h02;
         4'h7:    hex7 = 7'h78;
         4'h8:    hex7 = 7'h00;
         4'h9:    hex7 = 7'h10;
         4'hA:    hex7 = 7'h08;
         4'hB:    hex7 = 7'h03;
         4'hC:    hex7 = 7'h46;
         4'hD:    hex7 = 7'h21;
         4'hE:    hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // Prescaler, digit scan, frame-boundary snapshot and digit decode
   always_comb begin
      div_d       = div_q + DIV_W'(1);
      idx_d       = idx_q;
      snap_d      = snap_q;
      an_d        = an_q;
      seg_d       = seg_q;
      src_c       = Count_cycle;

      tick_c      = &div_q;
      nxt_idx_c   = idx_q + IDX_W'(1);
      frame_end_c = tick_c && (idx_q == LAST_IDX);
      shamt_c     = {nxt_idx_c, 2'b00};
      upper_c     = snap_q >> shamt_c;
      nib_c       = upper_c[NIB_W-1:0];
      blank_c     = BLANK && (nxt_idx_c != '0) && (upper_c == '0);
      dp_n_c      = !((nxt_idx_c == '0) && hold);

      case (sel)
         2'b01:   src_c = CountB;
         2'b10:   src_c = CountJ;
         default: src_c = Count_cycle;
      endcase

      if (tick_c) begin
         idx_d = nxt_idx_c;
         an_d  = ~(DIGIT_N'(1) << nxt_idx_c);
         seg_d = {dp_n_c, blank_c ? SEG_BLANK : hex7(nib_c)};
      end

      // Digit 0 on this same edge still decodes the old snapshot
      if (frame_end_c && !hold) begin
         snap_d = src_c;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         div_q  <= '0;
         idx_q  <= '0;
         snap_q <= '0;
         an_q   <= '1;
         seg_q  <= '1;
      end else begin
         div_q  <= div_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_counter_display.sv
// Randomized bench for counter_display: two instances (blanking off/on) checked
// against a frame/tick arithmetic model plus explicit digit patterns.
module tb_counter_display;

   localparam logic [6:0] HEXP [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [6:0] EXP_B [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] cnt_cycle, cnt_b, cnt_j;
   logic [1:0]  sel;
   logic        hold;
   logic [7:0]  an0, seg0, an1, seg1;

   int vecs = 0;
   int errs = 0;

   // Model state: clocks since release; a tick every 4th clock; frame = 8 ticks
   int          m_edges;
   int          m_n;
   logic [31:0] m_snap, m_sh;
   logic        m_dp;
   logic [7:0]  m_an, m_seg0, m_seg1;

   always #5 clk = ~clk;

   counter_display #(.DIV_W(2), .BLANK(1'b0)) u_nb (
      .clk(clk), .clr_n(clr_n), .Count_cycle(cnt_cycle), .CountB(cnt_b), .CountJ(cnt_j),
      .sel(sel), .hold(hold), .an(an0), .seg(seg0));

   counter_display #(.DIV_W(2), .BLANK(1'b1)) u_b (
      .clk(clk), .clr_n(clr_n), .Count_cycle(cnt_cycle), .CountB(cnt_b), .CountJ(cnt_j),
      .sel(sel), .hold(hold), .an(an1), .seg(seg1));

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_edges = 0;
         m_snap  = 32'd0;
         m_an    = 8'hFF;
         m_seg0  = 8'hFF;
         m_seg1  = 8'hFF;
      end else begin
         m_edges++;
         if (m_edges % 4 == 0) begin
            m_n    = (m_edges / 4) % 8;
            m_sh   = m_snap >> (4 * m_n);
            m_dp   = !(m_n == 0 && hold);
            m_an   = ~(8'd1 << m_n);
            m_seg0 = {m_dp, HEXP[m_sh[3:0]]};
            m_seg1 = {m_dp, (m_n != 0 && m_sh == 32'd0) ? 7'h7F : HEXP[m_sh[3:0]]};
            if (m_n == 0 && !hold)
               m_snap = (sel == 2'b01) ? cnt_b : (sel == 2'b10) ? cnt_j : cnt_cycle;
         end
      end
   end

   function automatic int digit_of(input logic [7:0] a);
      for (int i = 0; i < 8; i++)
         if (a == ~(8'd1 << i)) return i;
      return -1;
   endfunction

   task automatic test_reset();
      logic [7:0] exp_an;
      clr_n = 1'b0; hold = 1'b0; sel = 2'($urandom);
      cnt_cycle = $urandom; cnt_b = $urandom; cnt_j = $urandom;
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (9) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      vecs++;
      if ({an0, seg0, an1, seg1} !== 32'hFFFF_FFFF) begin
         errs++;
         $display("FAIL reset_async an0=%h seg0=%h an1=%h seg1=%h expected all FF", an0, seg0, an1, seg1);
      end
      @(negedge clk);
      clr_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         exp_an = (i / 4 == 0) ? 8'hFF : ~(8'd1 << ((i / 4) % 8));
         vecs++;
         if (an0 !== exp_an || an1 !== exp_an || (i < 4 && (seg0 !== 8'hFF || seg1 !== 8'hFF))) begin
            errs++;
            $display("FAIL reset_scan clk=%0d an0=%h an1=%h seg0=%h seg1=%h expected an=%h", i, an0, an1, seg0, seg1, exp_an);
         end
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL reset_model an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", an0, seg0, seg1, m_an, m_seg0, m_seg1);
         end
      end
   endtask

   task automatic test_source_b();
      int d, bnd2;
      sel = 2'b01; cnt_b = 32'h1234_ABCD; hold = 1'b0;
      bnd2 = 32 * (m_edges / 32 + 2);
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL source_b_model an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", an0, seg0, seg1, m_an, m_seg0, m_seg1);
         end
         d = digit_of(an0);
         if (m_edges >= bnd2) begin
            vecs++;
            if (d < 0 || seg0 !== {1'b1, EXP_B[d]}) begin
               errs++;
               $display("FAIL source_b_digit an0=%h seg0=%h expected digit pattern for 1234ABCD", an0, seg0);
            end
         end
         cnt_cycle = $urandom;
      end
   endtask

   task automatic test_blank();
      int d, bnd2;
      logic [31:0] vals [2] = '{32'h0000_0005, 32'h0000_0000};
      logic [7:0]  dig0 [2] = '{8'h92, 8'hC0};
      sel = 2'b10; hold = 1'b0;
      for (int p = 0; p < 2; p++) begin
         cnt_j = vals[p];
         bnd2 = 32 * (m_edges / 32 + 2);
         for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            vecs++;
            if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
               errs++;
               $display("FAIL blank_model an1=%h seg1=%h seg0=%h expected an=%h seg1=%h seg0=%h", an1, seg1, seg0, m_an, m_seg1, m_seg0);
            end
            d = digit_of(an1);
            if (m_edges >= bnd2) begin
               vecs++;
               if (d < 0 || seg1 !== ((d == 0) ? dig0[p] : 8'hFF)) begin
                  errs++;
                  $display("FAIL blank_digit countj=%h an1=%h seg1=%h expected %h", vals[p], an1, seg1, (d == 0) ? dig0[p] : 8'hFF);
               end
            end
            cnt_cycle = $urandom;
         end
      end
   endtask

   task automatic test_hold();
      int d, eh, bnd;
      logic [31:0] frozen;
      sel = 2'b00; hold = 1'b0;
      frozen = 32'd0;
      for (int c = 0; c < 83; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL hold_pre_model an0=%h seg0=%h expected an=%h seg0=%h", an0, seg0, m_an, m_seg0);
         end
         cnt_cycle++;
         if ((m_edges + 1) % 32 == 0) frozen = cnt_cycle;
      end
      hold = 1'b1;
      eh  = m_edges;
      bnd = 32 * (eh / 32 + 1);
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL hold_model an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", an0, seg0, seg1, m_an, m_seg0, m_seg1);
         end
         d = digit_of(an0);
         if (m_edges >= bnd) begin
            vecs++;
            if (d < 0 || seg0[7] !== (an0 != 8'hFE) || seg0[6:0] !== HEXP[4'(frozen >> (4 * d))]) begin
               errs++;
               $display("FAIL hold_frozen an0=%h seg0=%h frozen=%h", an0, seg0, frozen);
            end
         end
         cnt_cycle++;
      end
      hold = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL hold_release_model an0=%h seg0=%h expected an=%h seg0=%h", an0, seg0, m_an, m_seg0);
         end
         cnt_cycle++;
      end
   endtask

   task automatic test_hold_boundary();
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 40 && ((m_edges + 1) % 32 != 0); c++) @(negedge clk);
         hold = (p == 0);
         cnt_cycle = $urandom; cnt_b = $urandom; cnt_j = $urandom; sel = 2'($urandom);
         for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            vecs++;
            if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
               errs++;
               $display("FAIL hold_edge_model hold=%b an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", hold, an0, seg0, seg1, m_an, m_seg0, m_seg1);
            end
         end
      end
   endtask

   task automatic test_sel_switch();
      int d, bnd;
      logic [31:0] a, b, v;
      a = $urandom; b = $urandom;
      sel = 2'b00; hold = 1'b0; cnt_cycle = a; cnt_j = b;
      for (int c = 0; c < 64; c++) @(negedge clk);
      for (int c = 0; c < 40 && (m_edges % 32 != 13); c++) @(negedge clk);
      sel = 2'b10;
      bnd = 32 * (m_edges / 32 + 1);
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL sel_switch_model an0=%h seg0=%h expected an=%h seg0=%h", an0, seg0, m_an, m_seg0);
         end
         d = digit_of(an0);
         v = (m_edges >= bnd + 4) ? b : a;
         vecs++;
         if (d < 0 || seg0 !== {1'b1, HEXP[4'(v >> (4 * d))]}) begin
            errs++;
            $display("FAIL sel_switch_digit an0=%h seg0=%h source=%h", an0, seg0, v);
         end
      end
   endtask

   task automatic test_full_scale();
      int bnd2;
      sel = 2'b11; hold = 1'b0; cnt_cycle = 32'hFFFF_FFFF;
      bnd2 = 32 * (m_edges / 32 + 2);
      for (int c = 0; c < 96; c++) begin
         @(negedge clk);
         vecs++;
         if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
            errs++;
            $display("FAIL full_model an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", an0, seg0, seg1, m_an, m_seg0, m_seg1);
         end
         if (m_edges >= bnd2) begin
            vecs++;
            if (seg0 !== 8'h8E || seg1 !== 8'h8E) begin
               errs++;
               $display("FAIL full_digit an1=%h seg0=%h seg1=%h expected 8e", an1, seg0, seg1);
            end
         end
      end
   endtask

   task automatic test_random();
      int len;
      for (int b = 0; b < 30; b++) begin
         sel  = 2'($urandom);
         hold = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       begin cnt_cycle = 32'd0; cnt_b = $urandom_range(0, 255); cnt_j = 32'd0; end
            1:       begin cnt_cycle = $urandom_range(0, 65535); cnt_b = 32'd0; cnt_j = $urandom_range(0, 15); end
            default: begin cnt_cycle = $urandom; cnt_b = $urandom; cnt_j = $urandom; end
         endcase
         len = $urandom_range(5, 70);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            vecs++;
            if ({an0, seg0, an1, seg1} !== {m_an, m_seg0, m_an, m_seg1}) begin
               errs++;
               $display("FAIL random_model burst=%0d an0=%h seg0=%h seg1=%h expected an=%h seg0=%h seg1=%h", b, an0, seg0, seg1, m_an, m_seg0, m_seg1);
            end
            if (c == len / 2 && b % 10 == 9) begin
               #3 clr_n = 1'b0;
               #1 clr_n = 1'b1;
            end
         end
      end
   endtask

   initial begin
      clr_n = 1'b0; hold = 1'b0; sel = 2'b00;
      cnt_cycle = 32'd0; cnt_b = 32'd0; cnt_j = 32'd0;
      test_reset();
      test_source_b();
      test_blank();
      test_hold();
      test_hold_boundary();
      test_sel_switch();
      test_full_scale();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
